// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the pulse-shaping FIR sequencer: state encoding and phase width.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } fir_state_e;

    // A modulo-1 counter still needs one bit so the port is never zero-width.
    function automatic int phase_width(input int os_factor);
        return (os_factor > 1) ? $clog2(os_factor) : 1;
    endfunction

endpackage

// File: rtl/fir_ctrl_os_phase_cnt.sv
// Modulo-MODULUS phase counter with synchronous clear/enable and a wrap strobe.
module os_phase_cnt
    import fir_ctrl_pkg::*;
#(
    parameter int MODULUS = 4,
    parameter int W       = phase_width(MODULUS)
) (
    input  logic         clk,
    input  logic         i_reset_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] phase,
    output logic         wrap
);

    // wrap marks the last phase of a period while counting is enabled
    assign wrap = en && (phase == W'(MODULUS - 1));

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= wrap ? '0 : phase + W'(1);
        end
    end

endmodule

// File: rtl/fir_ctrl.sv
// Sequencer feeding a pulse-shaping FIR: zero-stuffs symbols by OS_FACTOR and flushes the tail on stop.
module fir_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int OS_FACTOR = 4,
    parameter int NUM_COEFF = 17,
    parameter int NBT_IN    = 8,
    parameter int PW        = phase_width(OS_FACTOR)
) (
    input  logic                     clk,
    input  logic                     i_reset_n,
    input  logic                     i_start,
    input  logic signed [NBT_IN-1:0] i_sym_data,
    input  logic                     i_sym_valid,
    output logic                     o_sym_ready,
    output logic signed [NBT_IN-1:0] o_fir_data,
    output logic                     o_fir_en,
    output logic                     o_fir_reset,
    output logic                     o_out_valid,
    output logic [PW-1:0]            o_phase,
    output logic                     o_busy,
    output logic                     o_underrun,
    output logic [1:0]               o_state
);

    localparam int FCW = $clog2(NUM_COEFF + 1);

    // Handshake: a symbol transfers in any cycle where i_sym_valid and o_sym_ready are both high;
    // o_sym_ready only ever rises at phase 0 of RUN and does not wait on i_sym_valid.

    fir_state_e     state_q, state_d;
    logic [FCW-1:0] flush_cnt_q;
    logic           phase_wrap;
    logic           flush_last;
    logic           phase_zero;

    os_phase_cnt #(
        .MODULUS (OS_FACTOR),
        .W       (PW)
    ) u_phase (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .clr       (state_q == PRIME),
        .en        (state_q == RUN),
        .phase     (o_phase),
        .wrap      (phase_wrap)
    );

    assign phase_zero = (o_phase == '0);
    assign flush_last = (flush_cnt_q == FCW'(NUM_COEFF - 1));

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = PRIME;
            PRIME:   state_d = RUN;
            // the current symbol period always completes before stopping
            RUN:     if (phase_wrap && !i_start) state_d = FLUSH;
            FLUSH:   if (flush_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            flush_cnt_q <= '0;
        end else if (state_q != FLUSH) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_q + FCW'(1);
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_out_valid <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            o_out_valid <= (state_q == RUN) || (state_q == FLUSH);
            if (state_q == PRIME) begin
                o_underrun <= 1'b0;
            end else if (state_q == RUN && phase_zero && !i_sym_valid) begin
                o_underrun <= 1'b1;
            end
        end
    end

    always_comb begin
        o_sym_ready = (state_q == RUN) && phase_zero;
        o_fir_en    = (state_q == RUN) || (state_q == FLUSH);
        o_fir_reset = (state_q == PRIME);
        o_busy      = (state_q != IDLE);
        o_fir_data  = '0;
        if (o_sym_ready && i_sym_valid) begin
            o_fir_data = i_sym_data;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl: reset, streaming, underrun, stop/flush, async reset, restart, OS_FACTOR=1.
module tb_fir_ctrl;
    import fir_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, sym_valid;
    logic [7:0] sym_data;
    logic       sym_ready, fir_en, fir_reset, out_valid, busy, underrun;
    logic [7:0] fir_data;
    logic [1:0] phase, state;

    logic       start1, valid1;
    logic [7:0] data1;
    logic       sym_ready1, fir_en1, fir_reset1, out_valid1, busy1, underrun1;
    logic [7:0] fir_data1;
    logic [0:0] phase1;
    logic [1:0] state1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fir_ctrl #(.OS_FACTOR(4), .NUM_COEFF(17), .NBT_IN(8)) dut (
        .clk (clk), .i_reset_n (rst_n), .i_start (start),
        .i_sym_data (sym_data), .i_sym_valid (sym_valid), .o_sym_ready (sym_ready),
        .o_fir_data (fir_data), .o_fir_en (fir_en), .o_fir_reset (fir_reset),
        .o_out_valid (out_valid), .o_phase (phase), .o_busy (busy),
        .o_underrun (underrun), .o_state (state)
    );

    fir_ctrl #(.OS_FACTOR(1), .NUM_COEFF(3), .NBT_IN(8)) dut1 (
        .clk (clk), .i_reset_n (rst_n), .i_start (start1),
        .i_sym_data (data1), .i_sym_valid (valid1), .o_sym_ready (sym_ready1),
        .o_fir_data (fir_data1), .o_fir_en (fir_en1), .o_fir_reset (fir_reset1),
        .o_out_valid (out_valid1), .o_phase (phase1), .o_busy (busy1),
        .o_underrun (underrun1), .o_state (state1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".sym_ready"}, sym_ready, 0);
        check({tag, ".fir_data"},  fir_data,  0);
        check({tag, ".fir_en"},    fir_en,    0);
        check({tag, ".fir_reset"}, fir_reset, 0);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".phase"},     phase,     0);
        check({tag, ".busy"},      busy,      0);
        check({tag, ".underrun"},  underrun,  0);
        check({tag, ".state"},     state,     0);
    endtask

    logic [7:0] exp_stream [8];
    logic [7:0] d1;

    initial begin
        exp_stream = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00};
        rst_n = 1'b0; start = 1'b1; sym_valid = 1'b0; sym_data = 8'h00;
        start1 = 1'b0; valid1 = 1'b0; data1 = 8'h00;

        // reset held with start high
        repeat (5) begin
            tick(); #1;
            check_all_zero("reset");
        end
        rst_n = 1'b1;

        tick(); #1;
        check("prime.state", state, 32'(PRIME));
        check("prime.fir_reset", fir_reset, 1);
        check("prime.fir_en", fir_en, 0);
        check("prime.busy", busy, 1);
        check("prime.sym_ready", sym_ready, 0);

        // streaming two symbols, valid always high
        for (int i = 0; i < 8; i++) begin
            tick();
            sym_valid = 1'b1;
            sym_data  = (i < 4) ? 8'h7F : 8'h81;
            #1;
            check($sformatf("stream%0d.state", i), state, 32'(RUN));
            check($sformatf("stream%0d.data", i), fir_data, exp_stream[i]);
            check($sformatf("stream%0d.ready", i), sym_ready, (i % 4 == 0) ? 1 : 0);
            check($sformatf("stream%0d.phase", i), phase, i % 4);
            check($sformatf("stream%0d.out_valid", i), out_valid, (i != 0) ? 1 : 0);
            check($sformatf("stream%0d.fir_en", i), fir_en, 1);
            check($sformatf("stream%0d.fir_reset", i), fir_reset, 0);
        end

        // underrun at phase 0
        tick(); sym_valid = 1'b0; sym_data = 8'h33; #1;
        check("under.phase", phase, 0);
        check("under.data", fir_data, 0);
        check("under.ready", sym_ready, 1);
        check("under.flag_pre", underrun, 0);

        // stop requested at phase 1
        tick(); sym_valid = 1'b1; start = 1'b0; #1;
        check("stop.phase1", phase, 1);
        check("stop.underrun", underrun, 1);
        check("stop.state1", state, 32'(RUN));
        tick(); #1;
        check("stop.phase2", phase, 2);
        check("stop.state2", state, 32'(RUN));
        tick(); #1;
        check("stop.phase3", phase, 3);
        check("stop.state3", state, 32'(RUN));

        for (int k = 0; k < 17; k++) begin
            tick(); sym_data = 8'h55; sym_valid = 1'b1; #1;
            check($sformatf("flush%0d.state", k), state, 32'(FLUSH));
            check($sformatf("flush%0d.fir_en", k), fir_en, 1);
            check($sformatf("flush%0d.data", k), fir_data, 0);
            check($sformatf("flush%0d.ready", k), sym_ready, 0);
            check($sformatf("flush%0d.out_valid", k), out_valid, 1);
            check($sformatf("flush%0d.underrun", k), underrun, 1);
        end
        tick(); #1;
        check("end.state", state, 32'(IDLE));
        check("end.fir_en", fir_en, 0);
        check("end.out_valid_hold", out_valid, 1);
        check("end.busy", busy, 0);
        tick(); #1;
        check("end.out_valid_fall", out_valid, 0);
        check("end.underrun_sticky", underrun, 1);

        // restart, then async reset in the 8th flush cycle
        start = 1'b1;
        tick(); #1;
        check("re.prime", state, 32'(PRIME));
        check("re.underrun_prime", underrun, 1);
        tick(); sym_valid = 1'b1; sym_data = 8'h10; start = 1'b0; #1;
        check("re.run", state, 32'(RUN));
        check("re.underrun_clr", underrun, 0);
        check("re.data", fir_data, 8'h10);
        repeat (3) begin
            tick(); #1;
        end
        check("re.phase3", phase, 3);
        for (int k = 0; k < 8; k++) begin
            tick(); #1;
            check($sformatf("rflush%0d.state", k), state, 32'(FLUSH));
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("async");
        tick(); #1;
        check_all_zero("async_hold");
        rst_n = 1'b1;
        tick(); #1;
        check("async.idle", state, 32'(IDLE));
        check("async.busy", busy, 0);

        // start held high across the whole flush
        start = 1'b1;
        tick(); #1;
        check("hold.prime", state, 32'(PRIME));
        tick(); sym_valid = 1'b0; #1;
        check("hold.run_p0", phase, 0);
        tick(); sym_valid = 1'b1; #1;
        check("hold.underrun", underrun, 1);
        tick(); #1;
        tick(); start = 1'b0; #1;
        check("hold.p3", phase, 3);
        tick(); start = 1'b1; #1;
        check("hold.flush0", state, 32'(FLUSH));
        for (int k = 1; k < 17; k++) begin
            tick(); #1;
            check($sformatf("hold.flush%0d", k), state, 32'(FLUSH));
        end
        tick(); #1;
        check("hold.idle", state, 32'(IDLE));
        check("hold.idle_en", fir_en, 0);
        tick(); #1;
        check("hold.prime2", state, 32'(PRIME));
        check("hold.prime2_reset", fir_reset, 1);
        check("hold.prime2_under", underrun, 1);
        tick(); #1;
        check("hold.run", state, 32'(RUN));
        check("hold.run_phase", phase, 0);
        check("hold.run_under", underrun, 0);
        check("hold.run_ready", sym_ready, 1);
        start = 1'b0;

        // OS_FACTOR=1: ready every RUN cycle, phase stuck at 0
        start1 = 1'b1;
        tick(); #1;
        check("os1.prime", state1, 32'(PRIME));
        for (int j = 0; j < 4; j++) begin
            tick();
            valid1 = 1'b1;
            d1 = 8'(j * 16 + 3);
            data1 = d1;
            if (j == 3) start1 = 1'b0;
            #1;
            check($sformatf("os1_%0d.state", j), state1, 32'(RUN));
            check($sformatf("os1_%0d.ready", j), sym_ready1, 1);
            check($sformatf("os1_%0d.phase", j), phase1, 0);
            check($sformatf("os1_%0d.data", j), fir_data1, d1);
        end
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            check($sformatf("os1_flush%0d", k), state1, 32'(FLUSH));
            check($sformatf("os1_flush%0d.ready", k), sym_ready1, 0);
        end
        tick(); #1;
        check("os1.idle", state1, 32'(IDLE));
        check("os1.underrun", underrun1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Sequencer for the transmit/receive pulse-shaping FIR. Accepts S(NBT_IN,NBF_IN) symbols over a valid/ready handshake, zero-stuffs them by OS_FACTOR, and drives the FIR's data, enable and reset inputs. On stop, it flushes the filter tail with NUM_COEFF zero samples before dropping the enable. It sits between the symbol source (PRBS/mapper) and the FIR in the top-level chain, and flags which FIR output samples are valid.

## Interface
- OS_FACTOR, 4: oversampling factor; must be ≥1.
- NUM_COEFF, 17: tap count of the driven FIR; sets the flush length.
- NBT_IN, 8: symbol and FIR input width.
- clk  in  1: clock, rising edge.
- i_reset_n  in  1: reset, asynchronous, active-low.
- i_start  in  1: run request, level-sensitive.
- i_sym_data  in  NBT_IN (signed): symbol sample.
- i_sym_valid  in  1: i_sym_data valid.
- o_sym_ready  out  1: symbol accepted this cycle when high together with i_sym_valid.
- o_fir_data  out  NBT_IN (signed): to the FIR data input.
- o_fir_en  out  1: to the FIR enable.
- o_fir_reset  out  1: to the FIR reset (active-high, synchronous in the FIR).
- o_out_valid  out  1: FIR output is valid this cycle.
- o_phase  out  max(1,$clog2(OS_FACTOR)): oversampling phase.
- o_busy  out  1: state is not IDLE.
- o_underrun  out  1: sticky flag; a zero was inserted for a missing symbol.

## Operation
- FSM states: IDLE, PRIME, RUN, FLUSH.
- IDLE: o_fir_en=0, o_fir_data=0. If i_start=1, go to PRIME.
- PRIME (one cycle): o_fir_reset=1, o_fir_en=0. Phase counter clears, o_underrun clears, then go to RUN.
- RUN: o_fir_en=1. Phase counts 0..OS_FACTOR-1 and wraps.
  - o_sym_ready = (state==RUN && phase==0), combinational.
  - At phase 0 with i_sym_valid=1: o_fir_data=i_sym_data.
  - At phase 0 with i_sym_valid=0: o_fir_data=0 and o_underrun is set.
  - At phase ≠0: o_fir_data=0.
- Leaving RUN: i_start is sampled every cycle. RUN ends only at the edge where phase==OS_FACTOR-1 and i_start=0; the symbol period always completes. Next state is FLUSH.
- FLUSH: o_fir_en=1, o_fir_data=0, o_sym_ready=0, for exactly NUM_COEFF cycles. A flush counter of width $clog2(NUM_COEFF+1) counts them. Then go to IDLE. i_start is ignored during FLUSH.
- o_out_valid: a register loaded with (state==RUN || state==FLUSH). It is high exactly one cycle after each cycle in which the FIR shifted a sample in.
- Async reset at any point, including mid-RUN or mid-FLUSH: immediately go to IDLE. All outputs are 0, counters 0, o_underrun=0.
- With OS_FACTOR=1, phase is constant 0 and o_sym_ready is high in every RUN cycle.

## Timing
- Reset values: o_sym_ready=0, o_fir_data=0, o_fir_en=0, o_fir_reset=0, o_out_valid=0, o_phase=0, o_busy=0, o_underrun=0.
- Registered elements: state, phase, flush counter, o_out_valid, o_underrun. o_fir_data, o_fir_en, o_fir_reset and o_sym_ready decode combinationally from registered state and inputs.
- Start latency: i_start seen high at edge n puts the FSM in PRIME during cycle n+1 and RUN from cycle n+2. The first o_sym_ready is in cycle n+2.
- Symbol latency: a symbol accepted in cycle t enters FIR tap 0 at the end of t. Its centre-tap peak appears in cycle t+1+(NUM_COEFF-1)/2.
- Stop latency: worst case OS_FACTOR-1 extra RUN cycles, then NUM_COEFF FLUSH cycles. o_fir_en falls in the first IDLE cycle; o_out_valid falls one cycle later.
- i_start still high in the first IDLE cycle after FLUSH: go to PRIME next cycle. There is no direct FLUSH→RUN path.

## Structure
- Package fir_ctrl_pkg holds the state encoding constants (IDLE=2'd0, PRIME=2'd1, RUN=2'd2, FLUSH=2'd3) and the phase-width function, shared with the chain top and the testbench.
- One natural sub-module: os_phase_cnt, a modulo-OS_FACTOR counter with synchronous clear/enable and a wrap strobe, used for the phase.
- The FIR itself is instantiated beside this block in the chain top, not inside it.

## Test plan
- Reset: hold i_reset_n=0 for 5 cycles with i_start=1 → every output 0. After release: PRIME one cycle later, o_fir_reset=1 for exactly one cycle.
- Stream (OS_FACTOR=4, symbols 8'h7F, 8'h81, valid always) → o_fir_data sequence 7F,00,00,00,81,00,00,00. o_sym_ready high in every 4th cycle. o_out_valid rises one cycle after the first RUN cycle.
- Underrun: i_sym_valid=0 at one phase-0 cycle → o_fir_data=00 in that cycle. o_underrun=1 and stays 1 until the next PRIME.
- Stop: drop i_start at phase 1 → RUN through phase 3, then 17 FLUSH cycles with o_fir_en=1 and data 0. Then o_fir_en=0, and o_out_valid=0 one cycle later.
- Async reset mid-FLUSH (cycle 8 of 17) → all outputs 0 in the same cycle. IDLE after release.
- i_start held high across the whole flush → one IDLE cycle, then PRIME, then RUN with phase=0 and o_underrun=0.
